// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared types and sizes for the FIFO-fed UART transmitter
package fifo_uart_pkg;

  localparam int DATA_W        = 8;
  localparam int NUM_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - FIFO read port, enable and serial-side signals of the transmitter
interface fifo_uart_tx_if;
  import fifo_uart_pkg::*;

  logic              en;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              txd;
  logic              busy;
  logic [7:0]        frames_sent;

  // master is the transmitter; slave is the FIFO/host side feeding it
  modport master (
    input  en,
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en,
    output txd,
    output busy,
    output frames_sent
  );

  modport slave (
    output en,
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en,
    input  txd,
    input  busy,
    input  frames_sent
  );

endinterface

// File: rtl/fifo_uart_tx_baud_cnt.sv
// rtl/fifo_uart_tx_baud_cnt.sv - bit-period counter, ticks on the last cycle of each bit
module uart_baud_cnt #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int              CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == CNT_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from a 1-cycle-latency FIFO and sends them as UART 8N1 frames
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master bus
);

  state_t            r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_frames;
  logic              r_txd;
  logic              w_tick;
  logic              w_baud_clr;
  logic              w_rd_en;

  // Held clear through IDLE/FETCH so every timed state starts at count 0;
  // timed states leave on the wrap, so the counter is already 0 on entry.
  assign w_baud_clr = (r_state == IDLE) || (r_state == FETCH);

  assign w_rd_en = ~rst & (r_state == IDLE) & bus.en & ~bus.fifo_empty;

  uart_baud_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_baud_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_frames  <= '0;
      r_txd     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rd_en) begin
            r_state <= FETCH;
          end
        end
        FETCH: begin
          r_shreg <= bus.fifo_dout;
          r_txd   <= 1'b0;
          r_state <= START;
        end
        START: begin
          if (w_tick) begin
            r_txd     <= r_shreg[0];
            r_bit_cnt <= '0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          // txd is loaded with the bit that will be in shreg[0] after this shift
          if (w_tick) begin
            r_shreg <= r_shreg >> 1;
            if (r_bit_cnt == 3'(NUM_DATA_BITS - 1)) begin
              r_txd   <= 1'b1;
              r_state <= STOP;
            end else begin
              r_txd     <= r_shreg[1];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_frames <= r_frames + 8'd1;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en  = w_rd_en;
  assign bus.txd         = r_txd;
  assign bus.busy        = (r_state != IDLE);
  assign bus.frames_sent = r_frames;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed bench for fifo_uart_tx with a behavioural 1-cycle-latency FIFO
module tb_fifo_uart_tx;

  localparam int CLK_DIV = 4;

  logic clk;
  logic rst;

  fifo_uart_tx_if bus ();

  fifo_uart_tx #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         cyc = 0;
  int         viol = 0;
  int         rd_pulses = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_frames = 8'd0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd_en) begin
      bus.fifo_dout <= mem[rd_ptr[9:0]];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (bus.fifo_rd_en && bus.fifo_empty) viol = viol + 1;
    if (bus.fifo_rd_en) rd_pulses = rd_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[9:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Waits for the pop, then checks every cycle of the frame; cut_k >= 0 drops en
  // (or pulses rst when cut_rst) right after frame cycle cut_k.
  task automatic run_frame(input logic [7:0] b, input int cut_k, input bit cut_rst, output int rc);
    int   n;
    logic exp_bit;
    n = 0;
    #1;
    while (!bus.fifo_rd_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rd_en_pulse", {31'd0, bus.fifo_rd_en}, 32'd1);
    rc = cyc;
    if (!bus.fifo_rd_en) return;
    @(negedge clk);
    check("fetch_txd", {31'd0, bus.txd}, 32'd1);
    check("fetch_busy", {31'd0, bus.busy}, 32'd1);
    check("fetch_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    for (int k = 0; k < 10 * CLK_DIV; k++) begin
      @(negedge clk);
      if (k < CLK_DIV) exp_bit = 1'b0;
      else if (k < 9 * CLK_DIV) exp_bit = b[(k - CLK_DIV) / CLK_DIV];
      else exp_bit = 1'b1;
      check($sformatf("txd_%02h_k%0d", b, k), {31'd0, bus.txd}, {31'd0, exp_bit});
      if (k == cut_k) begin
        if (cut_rst) begin
          rst = 1'b1;
          @(negedge clk);
          check("rst_txd", {31'd0, bus.txd}, 32'd1);
          check("rst_busy", {31'd0, bus.busy}, 32'd0);
          check("rst_frames", {24'd0, bus.frames_sent}, 32'd0);
          rst = 1'b0;
          exp_frames = 8'd0;
          return;
        end else begin
          bus.en = 1'b0;
        end
      end
    end
    @(negedge clk);
    exp_frames = exp_frames + 8'd1;
    check("end_busy", {31'd0, bus.busy}, 32'd0);
    check("end_frames", {24'd0, bus.frames_sent}, {24'd0, exp_frames});
  endtask

  initial begin
    int rc0, rc1, rc2;
    rst    = 1'b1;
    bus.en = 1'b1;

    // reset values and idle with an empty FIFO
    repeat (3) @(negedge clk);
    check("reset_txd", {31'd0, bus.txd}, 32'd1);
    check("reset_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_frames", {24'd0, bus.frames_sent}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_txd", {31'd0, bus.txd}, 32'd1);
      check("idle_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
      check("idle_busy", {31'd0, bus.busy}, 32'd0);
    end

    // single byte
    push(8'hA5);
    run_frame(8'hA5, -1, 1'b0, rc0);
    check("a5_pulses", rd_pulses, 32'd1);

    // three queued bytes back to back
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_frames = 8'd0;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    run_frame(8'h00, -1, 1'b0, rc0);
    run_frame(8'hFF, -1, 1'b0, rc1);
    run_frame(8'h3C, -1, 1'b0, rc2);
    check("gap_01", rc1 - rc0, 32'd42);
    check("gap_12", rc2 - rc1, 32'd42);
    check("three_frames", {24'd0, bus.frames_sent}, 32'd3);

    // en dropped mid-DATA: frame completes, nothing further popped
    push(8'h55);
    push(8'h66);
    run_frame(8'h55, 14, 1'b0, rc0);
    rc1 = rd_pulses;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("en_low_no_pop", {31'd0, bus.fifo_rd_en}, 32'd0);
    end
    check("en_low_busy", {31'd0, bus.busy}, 32'd0);
    check("en_low_pulses", rd_pulses, rc1);
    bus.en = 1'b1;
    run_frame(8'h66, -1, 1'b0, rc0);

    // reset mid-DATA drops the popped byte; next frame uses the next FIFO byte
    push(8'h11);
    push(8'h22);
    run_frame(8'h11, 14, 1'b1, rc0);
    run_frame(8'h22, -1, 1'b0, rc0);

    // 256 frames wrap the frame counter
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_frames = 8'd0;
    for (int i = 0; i < 256; i++) push(8'(i * 7 + 3));
    for (int i = 0; i < 256; i++) run_frame(8'(i * 7 + 3), -1, 1'b0, rc0);
    check("wrap_frames", {24'd0, bus.frames_sent}, 32'd0);
    check("empty_pop_violations", viol, 32'd0);
    check("total_pulses", rd_pulses, 32'd264);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the team's 8-bit synchronous FIFO: pops bytes whenever the FIFO is non-empty and serializes each byte as a UART 8N1 frame on `txd`. It sits between the FIFO's read port (`empty`, `rd_en`, registered `dout` with 1-cycle latency) and the board's serial pin. The block alone guarantees `fifo_rd_en` is never asserted while the FIFO is empty.

## Interface
- `CLK_DIV`, default 16: clk cycles per UART bit; legal range 2..65535.
- `clk`  in  1: system clock, all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `en`  in  1: transmit enable; sampled only in IDLE.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd_en`  out  1: FIFO read strobe, one-cycle pulse per byte.
- `fifo_dout`  in  8: FIFO read data, valid the cycle after `fifo_rd_en`.
- `txd`  out  1: serial line, idle high.
- `busy`  out  1: high whenever state is not IDLE.
- `frames_sent`  out  8: count of completed frames, wraps 255→0.

## Operation
- FSM states: IDLE, FETCH, START, DATA, STOP.
- IDLE: `fifo_rd_en = en & ~fifo_empty` (combinational from registered state); if asserted, go to FETCH next cycle, else stay.
- FETCH: exactly 1 cycle; capture `fifo_dout` into 8-bit shift register at end of cycle; go to START.
- START: `txd=0` for CLK_DIV cycles; go to DATA.
- DATA: `txd = shreg[0]`, LSB first; shift right every CLK_DIV cycles; 3-bit bit counter 0..7; after bit 7's period go to STOP.
- STOP: `txd=1` for CLK_DIV cycles; on last cycle increment `frames_sent`, go to IDLE.
- Baud counter: counts 0..CLK_DIV-1, cleared on every state entry; width ceil(log2(CLK_DIV)).
- `txd` is registered; equals 1 in IDLE and FETCH.
- `en` deasserted mid-frame: current frame completes; no new pop.
- `fifo_empty` is ignored outside IDLE; a frame in flight never aborts.

## Timing
- Reset values: `txd=1`, `fifo_rd_en=0`, `busy=0`, `frames_sent=0`, state IDLE, shreg 0, counters 0.
- rst mid-frame: next cycle `txd=1`, state IDLE; popped byte is dropped (not re-read).
- Latency: `fifo_rd_en` in cycle N → `txd` falls (start bit) at edge starting cycle N+2.
- Frame period: 10·CLK_DIV cycles of line activity; back-to-back period 10·CLK_DIV + 2 cycles (IDLE + FETCH gap, line held high).
- `fifo_rd_en` asserted at most once per frame period; never when `fifo_empty=1`.
- `busy` rises the cycle after `fifo_rd_en`, falls the cycle after the final STOP cycle.

## Structure
- Package `fifo_uart_pkg`: state enum (IDLE, FETCH, START, DATA, STOP), `DATA_W=8`, `NUM_DATA_BITS=8`.
- Sub-module `uart_baud_cnt`: parameter CLK_DIV; inputs clk, rst, clr; output `tick` on count CLK_DIV-1. FSM drives `clr` on state change.
- Top: FSM, shift register, bit counter, frame counter.

## Test plan
- Reset then idle with `fifo_empty=1`, `en=1` for 100 cycles, CLK_DIV=4 → `txd=1`, `fifo_rd_en=0`, `busy=0` throughout.
- One byte 0xA5, CLK_DIV=4 → one `fifo_rd_en` pulse; `txd` shows 0,1,0,1,0,0,1,0,1,1, 4 cycles each, starting 2 cycles after the pulse; `frames_sent=1`.
- Three bytes 0x00, 0xFF, 0x3C queued, CLK_DIV=4 → three frames, each 42 cycles apart, correct LSB-first bits; `frames_sent=3`.
- `en` dropped during DATA of byte 0x55 with 0x66 queued → 0x55 completes, no further `fifo_rd_en`, `busy=0`; re-raise `en` → 0x66 sent.
- `rst` pulsed mid-DATA → `txd=1` next cycle, `frames_sent=0`, next frame starts from next FIFO byte.
- 256 frames → `frames_sent` wraps to 0; model check `fifo_rd_en & fifo_empty` never true.
